debug_frame_sender: RTL and testbench
=====================================

# debug_frame_sender

Parametrised byte serializer for the debug unit. On a start pulse it snapshots a wide pipeline/debug state vector of arbitrary width and streams it to the UART transmitter one byte at a time, handshaking each byte on the transmitter's done pulse. It adds abort, busy/progress status, selectable byte order and an optional trailing checksum byte. It sits between the debug-unit command FSM and the UART TX.

## Interface
- DATA_W, 2626: width of the frame payload in bits; any value ≥ 1.
- MSB_FIRST, 0: 0 sends byte 0 (bits [7:0]) first; 1 sends the highest-index byte first.
- Derived: NBYTES = ceil(DATA_W/8); NTOT = NBYTES (+1 with checksum); IDX_W = clog2(NTOT+1).

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- i_data_from_pipe  in  DATA_W  frame payload, sampled only on accepted start.
- is_start  in  1  single-cycle start request.
- is_tx_done  in  1  single-cycle pulse from UART TX: current byte finished.
- is_abort  in  1  single-cycle abort request.
- o_tx_data  out  8  byte presented to UART TX.
- os_tx_start  out  1  single-cycle pulse: launch o_tx_data.
- os_done  out  1  single-cycle pulse: whole frame sent.
- o_busy  out  1  high while a frame is in progress.
- o_byte_idx  out  IDX_W  index (in send order) of the current byte.

## Operation
- States: IDLE, LOAD, WAIT, DONE.
- IDLE: is_start=1 and is_abort=0 → snapshot i_data_from_pipe into a shadow register (bits ≥ DATA_W padded with 0), idx←0, checksum←0, → LOAD. Otherwise stay.
- LOAD: o_tx_data←byte(idx), os_tx_start=1 for this cycle, checksum←checksum XOR byte, → WAIT.
- WAIT: is_tx_done=1 → idx==NTOT-1 ? DONE : (idx←idx+1, → LOAD). Else stay.
- DONE: os_done=1 for one cycle, → IDLE.
- byte(i): MSB_FIRST=0 → shadow[8i+7:8i]; MSB_FIRST=1 → shadow byte NBYTES-1-i. The checksum slot (i=NBYTES) sends the accumulated XOR.
- is_abort in LOAD/WAIT/DONE → IDLE next cycle; no os_done; o_tx_data holds its value. Abort has priority over is_tx_done and is_start in the same cycle.
- is_start outside IDLE is ignored. is_tx_done in IDLE/LOAD/DONE is ignored.
- The payload may change freely after the start is accepted; only the snapshot is sent.
- Reset (any state) → IDLE. All outputs 0: o_tx_data=0x00, os_tx_start=0, os_done=0, o_busy=0, o_byte_idx=0. Shadow register and checksum cleared.

## Timing
- is_start sampled at edge T → os_tx_start high in cycle T+1, with o_tx_data valid in the same cycle.
- o_tx_data is stable from os_tx_start until the next LOAD.
- is_tx_done sampled at edge T → next os_tx_start in T+1, or os_done in T+1 for the last byte.
- o_busy is high in LOAD and WAIT only, and low in DONE. A new is_start is accepted in the cycle after DONE.
- Minimum frame length with zero-latency TX: 2·NTOT+1 cycles from start to os_done.

## Configuration
- FRAME_SEND_CHECKSUM_EN defined: NTOT = NBYTES+1. The final byte is the XOR of all NBYTES payload bytes.
- FRAME_SEND_CHECKSUM_EN undefined: NTOT = NBYTES. No checksum register or logic is present.

## Structure
- Shared package debug_unit_pkg holds:
  - the state encoding (IDLE/LOAD/WAIT/DONE);
  - constant BYTE_W = 8;
  - ceil-div and clog2 helper functions.
- Sub-module frame_byte_mux (shadow, index, MSB_FIRST → byte) isolates the wide mux. The FSM, counter and checksum stay in the top module.

## Test plan
- DATA_W=2626, payload bits 0–3 and 2591 set, bits 2592–2623 = 0xFFFFFFFF, LSB-first → 329 bytes:
  - byte0 = 0x0F, byte323 = 0x80, bytes 324–327 = 0xFF, byte328 = 0x00, all others 0x00;
  - os_done one cycle after the 329th is_tx_done;
  - with checksum enabled: byte 329 = 0x8F.
- DATA_W=12, payload 0xABC:
  - MSB_FIRST=0 → 0xBC, 0x0A;
  - MSB_FIRST=1 → 0x0A, 0xBC;
  - with checksum enabled: a third byte 0xB6 in both cases.
- Abort in WAIT at byte 5 → o_busy low next cycle, no os_done, no further os_tx_start. A fresh start then sends byte 0 again.
- is_start pulsed mid-frame, and is_tx_done pulsed in IDLE → both ignored; the byte sequence and count are unchanged.
- is_abort and is_tx_done in the same cycle → IDLE; is_start with is_abort in IDLE → stays IDLE.
- rst low during WAIT → next cycle all outputs 0 and state IDLE. The payload changing after start does not alter the transmitted bytes.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: state encoding, byte width and sizing helpers shared by the
// debug unit blocks (frame sender FSM and its byte multiplexer).
package debug_unit_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } frame_state_t;

   // Integer ceiling division, used to size the byte count of a payload.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2_int(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// frame_byte_mux: selects one byte of the shadowed frame by its send-order
// index. Each byte slot decodes its own send position once; the output is a
// per-bit OR across the one-hot masked slots, so the wide select stays flat.
// Indices at or beyond NBYTES (e.g. the checksum slot) yield 0x00.
module frame_byte_mux
   import debug_unit_pkg::*;
#(
   parameter int NBYTES    = 1,
   parameter int MSB_FIRST = 0,
   parameter int IDX_W     = 1
) (
   input  logic [NBYTES*BYTE_W-1:0] i_shadow,
   input  logic [IDX_W-1:0]         i_idx,
   output logic [BYTE_W-1:0]        o_byte
);

   logic [NBYTES-1:0] w_hit;
   logic [NBYTES-1:0] w_col [BYTE_W];

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_slot
         // Send-order position at which storage byte gi goes out.
         localparam int SLOT = (MSB_FIRST != 0) ? (NBYTES - 1 - gi) : gi;
         assign w_hit[gi] = (i_idx == IDX_W'(SLOT));
         for (genvar gb = 0; gb < BYTE_W; gb++) begin : g_bit
            assign w_col[gb][gi] = w_hit[gi] & i_shadow[gi*BYTE_W + gb];
         end
      end
      for (genvar gb = 0; gb < BYTE_W; gb++) begin : g_out
         assign o_byte[gb] = |w_col[gb];
      end
   endgenerate

endmodule

// File: rtl/debug_frame_sender.sv
// debug_frame_sender: snapshots a DATA_W-bit debug frame on start and streams
// it byte by byte to the UART TX, one byte per is_tx_done handshake.
// Optional trailing XOR checksum byte: define FRAME_SEND_CHECKSUM_EN.
module debug_frame_sender
   import debug_unit_pkg::*;
#(
   parameter int DATA_W    = 2626,
   parameter int MSB_FIRST = 0,
`ifdef FRAME_SEND_CHECKSUM_EN
   localparam int NTOT     = ceil_div(DATA_W, BYTE_W) + 1,
`else
   localparam int NTOT     = ceil_div(DATA_W, BYTE_W),
`endif
   localparam int IDX_W    = clog2_int(NTOT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data_from_pipe,
   input  logic              is_start,
   input  logic              is_tx_done,
   input  logic              is_abort,
   output logic [7:0]        o_tx_data,
   output logic              os_tx_start,
   output logic              os_done,
   output logic              o_busy,
   output logic [IDX_W-1:0]  o_byte_idx
);

   localparam int NBYTES = ceil_div(DATA_W, BYTE_W);
   localparam int PAD_W  = NBYTES * BYTE_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTOT - 1);

   frame_state_t        r_state;
   logic [PAD_W-1:0]    r_shadow;
   logic [IDX_W-1:0]    r_idx;
   logic [BYTE_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic                r_done;
   logic                r_busy;
   logic [PAD_W-1:0]    w_padded;
   logic [BYTE_W-1:0]   w_mux_byte;
   logic [BYTE_W-1:0]   w_cur_byte;
   logic                w_accept;

   // Zero-extend the payload up to a whole number of bytes.
   generate
      if (PAD_W > DATA_W) begin : g_pad
         assign w_padded = {{(PAD_W - DATA_W){1'b0}}, i_data_from_pipe};
      end else begin : g_nopad
         assign w_padded = i_data_from_pipe;
      end
   endgenerate

   assign w_accept = (r_state == IDLE) && is_start && !is_abort;

   frame_byte_mux #(
      .NBYTES    (NBYTES),
      .MSB_FIRST (MSB_FIRST),
      .IDX_W     (IDX_W)
   ) u_byte_mux (
      .i_shadow (r_shadow),
      .i_idx    (r_idx),
      .o_byte   (w_mux_byte)
   );

`ifdef FRAME_SEND_CHECKSUM_EN
   logic [BYTE_W-1:0] r_chk;
   logic              w_chk_slot;

   assign w_chk_slot = (r_idx == IDX_W'(NBYTES));
   assign w_cur_byte = w_chk_slot ? r_chk : w_mux_byte;

   // Running XOR of payload bytes, restarted on each accepted frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_chk <= '0;
      end else if (w_accept) begin
         r_chk <= '0;
      end else if (r_state == LOAD && !w_chk_slot) begin
         r_chk <= r_chk ^ w_mux_byte;
      end
   end
`else
   assign w_cur_byte = w_mux_byte;
`endif

   // Frame sequencing FSM: accept, launch each byte, await TX done, finish.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_shadow   <= '0;
         r_idx      <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shadow   <= w_padded;
                  r_idx      <= '0;
                  r_state    <= LOAD;
                  r_tx_start <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            LOAD: begin
               // Latch the launched byte so it holds through WAIT and after abort.
               r_tx_data <= w_cur_byte;
               if (is_abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (is_abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (is_tx_done) begin
                  if (r_idx == LAST_IDX) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx      <= r_idx + 1'b1;
                     r_state    <= LOAD;
                     r_tx_start <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // The byte is shown live during the launch cycle, then held from its latch.
   assign o_tx_data   = r_tx_start ? w_cur_byte : r_tx_data;
   assign os_tx_start = r_tx_start;
   assign os_done     = r_done;
   assign o_busy      = r_busy;
   assign o_byte_idx  = r_idx;

endmodule

// File: tb/tb_debug_frame_sender.sv
// tb_debug_frame_sender: randomized and directed stimulus for
// debug_frame_sender against a cycle-level behavioural model of the frame
// protocol, plus literal expectations for the known-answer frames.
module tb_debug_frame_sender;

   localparam int DATA_W = 2626;
   localparam int MSB    = 0;
   localparam int NB     = (DATA_W + 7) / 8;
`ifdef FRAME_SEND_CHECKSUM_EN
   localparam int CHK    = 1;
`else
   localparam int CHK    = 0;
`endif
   localparam int NT     = NB + CHK;
   localparam int IDX_W  = $clog2(NT + 1);
   localparam int SNT    = 2 + CHK;
   localparam int SIDX_W = $clog2(SNT + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [DATA_W-1:0] data;
   logic              is_start, is_tx_done, is_abort;
   logic [7:0]        o_tx_data;
   logic              os_tx_start, os_done, o_busy;
   logic [IDX_W-1:0]  o_byte_idx;

   logic [11:0]       s_data;
   logic              s_start, s_done, s_abort;
   logic [7:0]        s0_tx_data, s1_tx_data;
   logic              s0_start, s0_done, s0_busy, s1_start, s1_done, s1_busy;
   logic [SIDX_W-1:0] s0_idx, s1_idx;

   debug_frame_sender #(.DATA_W(DATA_W), .MSB_FIRST(MSB)) u_dut (
      .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
      .is_tx_done(is_tx_done), .is_abort(is_abort), .o_tx_data(o_tx_data),
      .os_tx_start(os_tx_start), .os_done(os_done), .o_busy(o_busy),
      .o_byte_idx(o_byte_idx));

   debug_frame_sender #(.DATA_W(12), .MSB_FIRST(0)) u_small_lsb (
      .clk(clk), .rst(rst), .i_data_from_pipe(s_data), .is_start(s_start),
      .is_tx_done(s_done), .is_abort(s_abort), .o_tx_data(s0_tx_data),
      .os_tx_start(s0_start), .os_done(s0_done), .o_busy(s0_busy),
      .o_byte_idx(s0_idx));

   debug_frame_sender #(.DATA_W(12), .MSB_FIRST(1)) u_small_msb (
      .clk(clk), .rst(rst), .i_data_from_pipe(s_data), .is_start(s_start),
      .is_tx_done(s_done), .is_abort(s_abort), .o_tx_data(s1_tx_data),
      .os_tx_start(s1_start), .os_done(s1_done), .o_busy(s1_busy),
      .o_byte_idx(s1_idx));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_launch, m_active, m_done;
   int         m_idx;
   logic [7:0] m_hold;
   logic [7:0] m_exp [NT];
   logic [7:0] m_x;
   int         m_pos;

   always @(posedge clk) begin
      if (m_launch) m_hold = m_exp[m_idx];
      if (!rst) begin
         m_launch = 0; m_active = 0; m_done = 0; m_idx = 0; m_hold = 8'h00;
      end else if ((m_active || m_done) && is_abort) begin
         m_launch = 0; m_active = 0; m_done = 0;
      end else if (!m_active && !m_done) begin
         if (is_start && !is_abort) begin
            m_x = 8'h00;
            for (int i = 0; i < NB; i++) begin
               m_pos = (MSB != 0) ? (NB - 1 - i) : i;
               m_exp[i] = 8'((data >> (8 * m_pos)) & 'hFF);
               m_x = m_x ^ m_exp[i];
            end
            if (CHK != 0) m_exp[NT-1] = m_x;
            m_idx = 0; m_active = 1; m_launch = 1;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (m_launch) begin
         m_launch = 0;
      end else if (is_tx_done) begin
         if (m_idx == NT - 1) begin
            m_active = 0; m_done = 1;
         end else begin
            m_idx = m_idx + 1; m_launch = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_start", 32'(os_tx_start), 32'(m_launch));
         chk("done", 32'(os_done), 32'(m_done));
         chk("busy", 32'(o_busy), 32'(m_active));
         chk("tx_data", 32'(o_tx_data), 32'(m_launch ? m_exp[m_idx] : m_hold));
         if (m_active) chk("byte_idx", 32'(o_byte_idx), 32'(m_idx));
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] cap[$];
   logic [7:0] s_cap0[$];
   logic [7:0] s_cap1[$];
   int  pend = 0, max_lat = 0, done_seen = 0, starts_seen = 0, last_len = 0;
   int  s_done_cnt = 0, s1_done_cnt = 0;
   bit  s_pend = 0, auto_en = 0, glitch_en = 0, churn_en = 0;

   task automatic step();
      @(posedge clk);
      #1;
      is_start = 0; is_abort = 0; is_tx_done = 0; s_start = 0; s_done = 0;
      if (churn_en) data[$urandom_range(0, DATA_W - 1)] ^= 1'b1;
      if (pend > 0) begin
         pend--;
         if (pend == 0) is_tx_done = 1;
      end
      if (os_tx_start) begin
         cap.push_back(o_tx_data);
         starts_seen++;
         if (auto_en) pend = 1 + int'($urandom_range(0, max_lat));
      end
      if (os_done) done_seen++;
      if (glitch_en && (o_busy || os_done) && $urandom_range(0, 60) == 0) is_start = 1;
      if (glitch_en && !o_busy && $urandom_range(0, 10) == 0) is_tx_done = 1;
      if (s_pend) begin s_done = 1; s_pend = 0; end
      if (s0_start) begin
         chk("small_idx", 32'(s0_idx), 32'(s_cap0.size()));
         s_cap0.push_back(s0_tx_data);
         s_pend = 1;
      end
      if (s1_start) begin
         chk("small_msb_idx", 32'(s1_idx), 32'(s_cap1.size()));
         s_cap1.push_back(s1_tx_data);
      end
      if (s0_done) s_done_cnt++;
      if (s1_done) s1_done_cnt++;
   endtask

   function automatic logic [DATA_W-1:0] rand_payload();
      logic [DATA_W-1:0] p;
      p = '0;
      for (int i = 0; i < DATA_W; i += 32) p = {p[DATA_W-33:0], 32'($urandom)};
      return p;
   endfunction

   task automatic run_frame(input int lat, input bit glitch, input logic [DATA_W-1:0] payload);
      int n, d0;
      auto_en = 1; max_lat = lat;
      step();
      data = payload; is_start = 1;
      d0 = done_seen; n = 0;
      glitch_en = glitch; churn_en = 1;
      while (done_seen == d0 && n < 6000) begin step(); n++; end
      glitch_en = 0; churn_en = 0;
      chk("frame_completes", 32'(done_seen != d0), 32'd1);
      last_len = n;
      $display("frame: lat<=%0d glitch=%0d cycles=%0d bytes=%0d", lat, glitch, n, cap.size());
   endtask

   // ---------------- test sequence ----------------
   logic [DATA_W-1:0] p;
   int n, st, d0;

   initial begin
      rst = 0; data = '0; s_data = '0; s_abort = 0;
      is_start = 0; is_abort = 0; is_tx_done = 0; s_start = 0; s_done = 0;
      step();
      chk_en = 1;
      step(); step();
      rst = 1;
      step();
      chk("rst_tx_data", 32'(o_tx_data), 32'h0);
      chk("rst_idx", 32'(o_byte_idx), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);

      // tx_done in IDLE is ignored
      is_tx_done = 1;
      step();
      chk("idle_done_busy", 32'(o_busy), 32'h0);
      step();
      chk("idle_done_start", 32'(os_tx_start), 32'h0);

      // known-answer wide frame, payload churning after start, stray starts mid-frame
      p = '0; p[3:0] = 4'hF; p[2591] = 1'b1; p[2623:2592] = 32'hFFFF_FFFF;
      cap.delete();
      run_frame(2, 1, p);
      chk("kat_count", 32'(cap.size()), 32'(NT));
      chk("kat_b0", 32'(cap[0]), 32'h0F);
      chk("kat_b323", 32'(cap[323]), 32'h80);
      for (int i = 324; i < 328; i++) chk("kat_b324_327", 32'(cap[i]), 32'hFF);
      chk("kat_b328", 32'(cap[328]), 32'h00);
      chk("kat_b1", 32'(cap[1]), 32'h00);
      if (CHK != 0) chk("kat_chk", 32'(cap[NB]), 32'h8F);

      // zero-latency TX: shortest possible frame
      cap.delete();
      run_frame(0, 0, rand_payload());
      chk("min_frame_len", 32'(last_len), 32'(2 * NT + 1));

      // abort in WAIT at byte 5
      auto_en = 1; max_lat = 3;
      step();
      data = rand_payload(); is_start = 1;
      n = 0;
      step();
      while (!(o_busy && !os_tx_start && o_byte_idx == IDX_W'(5)) && n < 200) begin step(); n++; end
      chk("reach_byte5", 32'(o_byte_idx), 32'd5);
      is_abort = 1;
      step();
      pend = 0;
      chk("abort_busy", 32'(o_busy), 32'h0);
      st = starts_seen; d0 = done_seen;
      repeat (12) step();
      chk("abort_no_start", 32'(starts_seen - st), 32'h0);
      chk("abort_no_done", 32'(done_seen - d0), 32'h0);
      p = rand_payload();
      cap.delete();
      run_frame(1, 0, p);
      chk("restart_b0", 32'(cap[0]), 32'(p[7:0]));
      chk("restart_count", 32'(cap.size()), 32'(NT));

      // abort and tx_done in the same cycle
      auto_en = 0; pend = 0;
      step();
      data = rand_payload(); is_start = 1;
      step(); step();
      chk("wait_busy", 32'(o_busy), 32'h1);
      is_abort = 1; is_tx_done = 1;
      step();
      chk("abort_done_busy", 32'(o_busy), 32'h0);
      chk("abort_done_done", 32'(os_done), 32'h0);
      step();
      chk("abort_done_nostart", 32'(os_tx_start), 32'h0);

      // abort in LOAD keeps the launched byte on o_tx_data
      p = rand_payload();
      step();
      data = p; is_start = 1;
      step();
      chk("load_start", 32'(os_tx_start), 32'h1);
      is_abort = 1;
      step();
      chk("abort_load_busy", 32'(o_busy), 32'h0);
      chk("abort_load_hold", 32'(o_tx_data), 32'(p[7:0]));

      // start together with abort in IDLE is refused
      step();
      is_start = 1; is_abort = 1;
      step();
      chk("start_abort_busy", 32'(o_busy), 32'h0);
      step();
      chk("start_abort_nostart", 32'(os_tx_start), 32'h0);

      // reset during WAIT clears every output
      step();
      data = rand_payload(); is_start = 1;
      step(); step();
      chk("pre_reset_busy", 32'(o_busy), 32'h1);
      rst = 0;
      step();
      chk("rstw_tx_data", 32'(o_tx_data), 32'h0);
      chk("rstw_tx_start", 32'(os_tx_start), 32'h0);
      chk("rstw_done", 32'(os_done), 32'h0);
      chk("rstw_busy", 32'(o_busy), 32'h0);
      chk("rstw_idx", 32'(o_byte_idx), 32'h0);
      rst = 1;
      step();

      // 12-bit frames, both byte orders
      s_cap0.delete(); s_cap1.delete();
      s_data = 12'hABC; s_start = 1;
      step();
      s_data = 12'h5A5;
      repeat (16) step();
      chk("small_count", 32'(s_cap0.size()), 32'(SNT));
      chk("small_lsb_b0", 32'(s_cap0[0]), 32'hBC);
      chk("small_lsb_b1", 32'(s_cap0[1]), 32'h0A);
      chk("small_msb_count", 32'(s_cap1.size()), 32'(SNT));
      chk("small_msb_b0", 32'(s_cap1[0]), 32'h0A);
      chk("small_msb_b1", 32'(s_cap1[1]), 32'hBC);
      if (CHK != 0) begin
         chk("small_lsb_chk", 32'(s_cap0[2]), 32'hB6);
         chk("small_msb_chk", 32'(s_cap1[2]), 32'hB6);
      end
      chk("small_done_cnt", 32'(s_done_cnt), 32'd1);
      chk("small_msb_done_cnt", 32'(s1_done_cnt), 32'd1);
      chk("small_idle", 32'({s0_busy, s1_busy}), 32'h0);

      // randomized frames with stray pulses and varying TX latency
      for (int f = 0; f < 4; f++) begin
         cap.delete();
         run_frame(3, 1, rand_payload());
         chk("rand_count", 32'(cap.size()), 32'(NT));
         repeat (3) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
